bram_read_stream: RTL and testbench

Downstream consumer of the BRAM controller's read port. Snoops the controller's enable/write-enable/address outputs together with the BRAM data output, realigns read data with its address across the BRAM read latency, and presents it as a valid/ready stream through a small FIFO. Also computes a per-frame checksum and flags data loss; the controller has no stall input, so this block absorbs back-pressure or reports overflow.

---
 rtl/bram_pkg.sv | 17 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/bram_read_stream.sv | 127 ++++++++++++
 tb/tb_bram_read_stream.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM read-stream path.
package bram_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned SUM_W_DEF  = DATA_W_DEF + ADDR_W_DEF;

  // Highest address of a frame at the default address width.
  localparam logic [ADDR_W_DEF-1:0] FRAME_LAST = ADDR_W_DEF'((1 << ADDR_W_DEF) - 1);

  // One stream word at default widths.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [ADDR_W_DEF-1:0] addr;
  } stream_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; output forced to zero when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_full    = (r_count == LW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign w_pop_ok  = i_pop && !o_empty;
  // A push into a full FIFO is only taken when a pop frees a slot the same cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + LW'(w_push_ok) - LW'(w_pop_ok);
    end
  end

  // Storage write; contents need no reset since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/bram_read_stream.sv
// Realigns BRAM read data with its address, streams it through a FIFO,
// keeps a per-frame checksum and flags dropped words.
module bram_read_stream
  import bram_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        wea,
  input  logic [ADDR_W-1:0]           addra,
  input  logic [DATA_W-1:0]           douta,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic [ADDR_W-1:0]           m_addr,
  output logic                        m_last,
  output logic [DATA_W+ADDR_W-1:0]    frame_sum,
  output logic                        frame_sum_valid,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned SUM_W = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } word_t;

  logic [RD_LAT-1:0] r_tag_vld;
  logic [ADDR_W-1:0] r_tag_addr [RD_LAT];
  logic [SUM_W-1:0]  r_acc;
  logic [SUM_W-1:0]  r_frame_sum;
  logic              r_frame_sum_valid;
  logic              r_overflow;

  logic              w_push;
  logic [ADDR_W-1:0] w_push_addr;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic              w_frame_end;
  logic [SUM_W-1:0]  w_sum_next;
  word_t             w_wword;
  word_t             w_rword;

  // Tag pipeline: carries read-issue valid and address across the BRAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) r_tag_addr[i] <= '0;
    end else begin
      r_tag_vld[0]  <= ena && !wea;
      r_tag_addr[0] <= addra;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_addr[i] <= r_tag_addr[i-1];
      end
    end
  end

  assign w_push       = r_tag_vld[RD_LAT-1];
  assign w_push_addr  = r_tag_addr[RD_LAT-1];
  assign w_pop        = !w_empty && m_ready;
  assign w_drop       = w_push && w_full && !w_pop;
  assign w_frame_end  = w_push && (w_push_addr == LAST_ADDR);
  assign w_sum_next   = r_acc + SUM_W'(douta);
  assign w_wword.data = douta;
  assign w_wword.addr = w_push_addr;

  sync_fifo #(
    .WIDTH (SUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wword),
    .o_rdata (w_rword),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Checksum over every push attempt, dropped words included; frame closes on max address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc             <= '0;
      r_frame_sum       <= '0;
      r_frame_sum_valid <= 1'b0;
    end else begin
      r_frame_sum_valid <= 1'b0;
      if (w_push) begin
        if (w_frame_end) begin
          r_frame_sum       <= w_sum_next;
          r_frame_sum_valid <= 1'b1;
          r_acc             <= '0;
        end else begin
          r_acc <= w_sum_next;
        end
      end
    end
  end

  // Sticky loss flag: set when a push meets a full FIFO with no pop.
  always_ff @(posedge clk) begin
    if (rst)         r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign m_valid         = !w_empty;
  assign m_data          = w_rword.data;
  assign m_addr          = w_rword.addr;
  assign m_last          = m_valid && (w_rword.addr == LAST_ADDR);
  assign frame_sum       = r_frame_sum;
  assign frame_sum_valid = r_frame_sum_valid;
  assign overflow        = r_overflow;

endmodule

// File: tb/tb_bram_read_stream.sv
// Scoreboard bench: two instances (read latency 1 and 2) share controller
// stimulus, each fed by its own BRAM model of matching latency.
module tb_bram_read_stream;
  import bram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ena, wea, m_ready;
  logic [4:0] addra;
  logic [7:0] douta1, douta2;
  logic [7:0] mem [32];

  logic        m_valid1, m_last1, fsv1, ovf1;
  logic [7:0]  m_data1;
  logic [4:0]  m_addr1;
  logic [12:0] fsum1;
  logic [2:0]  lvl1;
  logic        m_valid2, m_last2, fsv2, ovf2;
  logic [7:0]  m_data2;
  logic [4:0]  m_addr2;
  logic [12:0] fsum2;
  logic [2:0]  lvl2;

  bram_read_stream #(.DATA_W(8), .ADDR_W(5), .RD_LAT(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .douta(douta1),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_addr(m_addr1),
    .m_last(m_last1), .frame_sum(fsum1), .frame_sum_valid(fsv1),
    .overflow(ovf1), .fifo_level(lvl1));

  bram_read_stream #(.DATA_W(8), .ADDR_W(5), .RD_LAT(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .douta(douta2),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_addr(m_addr2),
    .m_last(m_last2), .frame_sum(fsum2), .frame_sum_valid(fsv2),
    .overflow(ovf2), .fifo_level(lvl2));

  // BRAM models: read-first, latency 1 and latency 2.
  always @(posedge clk) begin
    if (ena) douta1 <= mem[addra];
    douta2 <= douta1;
  end

  stream_word_t exp1[$], exp2[$];
  logic [12:0]  sq1[$], sq2[$];
  logic [12:0]  b_acc;
  int errs, checks;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_word(input string nm, input stream_word_t e,
                            input logic [7:0] d, input logic [4:0] a, input logic l);
    checks++;
    if (d != e.data || a != e.addr || l != (e.addr == 5'd31)) begin
      errs++;
      $display("FAIL %s: got data=%0d addr=%0d last=%0b expected data=%0d addr=%0d last=%0b",
               nm, d, a, l, e.data, e.addr, (e.addr == 5'd31));
    end
  endtask

  task automatic check_sum(input string nm, input logic [12:0] got, input logic [12:0] e);
    checks++;
    if (got != e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, e);
    end
  endtask

  // Monitor: pops expectations whenever a DUT delivers a word or a checksum pulse.
  task automatic monitor();
    stream_word_t w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_valid1 && m_ready) begin
          if (exp1.size() == 0) begin
            checks++; errs++;
            $display("FAIL u1 unexpected word: got data=%0d addr=%0d expected none", m_data1, m_addr1);
          end else begin
            w = exp1.pop_front();
            check_word("u1 word", w, m_data1, m_addr1, m_last1);
          end
        end
        if (m_valid2 && m_ready) begin
          if (exp2.size() == 0) begin
            checks++; errs++;
            $display("FAIL u2 unexpected word: got data=%0d addr=%0d expected none", m_data2, m_addr2);
          end else begin
            w = exp2.pop_front();
            check_word("u2 word", w, m_data2, m_addr2, m_last2);
          end
        end
        if (fsv1) begin
          if (sq1.size() == 0) begin
            checks++; errs++;
            $display("FAIL u1 unexpected frame_sum pulse: got %0d expected none", fsum1);
          end else check_sum("u1 frame_sum", fsum1, sq1.pop_front());
        end
        if (fsv2) begin
          if (sq2.size() == 0) begin
            checks++; errs++;
            $display("FAIL u2 unexpected frame_sum pulse: got %0d expected none", fsum2);
          end else check_sum("u2 frame_sum", fsum2, sq2.pop_front());
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one read; keep=0 marks a word the bench expects to be dropped.
  task automatic rd(input int a, input bit keep);
    stream_word_t w;
    ena = 1'b1; wea = 1'b0; addra = 5'(a);
    step();
    w.data = mem[a];
    w.addr = 5'(a);
    if (keep) begin
      exp1.push_back(w);
      exp2.push_back(w);
    end
    b_acc = b_acc + 13'(mem[a]);
    if (a == 31) begin
      sq1.push_back(b_acc);
      sq2.push_back(b_acc);
      b_acc = '0;
    end
  endtask

  task automatic wr(input int a);
    ena = 1'b1; wea = 1'b1; addra = 5'(a);
    step();
  endtask

  task automatic idle(input int n);
    ena = 1'b0; wea = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    ena = 1'b0; wea = 1'b0;
    while ((exp1.size() + exp2.size() + sq1.size() + sq2.size()) != 0 && k < 100) begin
      step();
      k++;
    end
    idle(2);
    check({nm, " drain pending"}, exp1.size() + exp2.size() + sq1.size() + sq2.size(), 0);
  endtask

  task automatic check_zero(input string nm);
    check({nm, " u1 m_valid"}, int'(m_valid1), 0);
    check({nm, " u1 m_data"},  int'(m_data1), 0);
    check({nm, " u1 m_addr"},  int'(m_addr1), 0);
    check({nm, " u1 m_last"},  int'(m_last1), 0);
    check({nm, " u1 level"},   int'(lvl1), 0);
    check({nm, " u1 sum"},     int'(fsum1), 0);
    check({nm, " u1 sumv"},    int'(fsv1), 0);
    check({nm, " u1 ovf"},     int'(ovf1), 0);
    check({nm, " u2 m_valid"}, int'(m_valid2), 0);
    check({nm, " u2 level"},   int'(lvl2), 0);
    check({nm, " u2 ovf"},     int'(ovf2), 0);
  endtask

  initial begin
    errs = 0; checks = 0; b_acc = '0;
    rst = 1'b1; ena = 1'b0; wea = 1'b0; addra = '0; m_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i + 1);
    fork monitor(); join_none
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;

    // Straight frame, consumer always ready; latency of first word per instance.
    m_ready = 1'b1;
    rd(0, 1);
    check("t1 u1 no valid yet", int'(m_valid1), 0);
    rd(1, 1);
    check("t1 u1 valid at +2", int'(m_valid1), 1);
    check("t1 u2 no valid yet", int'(m_valid2), 0);
    rd(2, 1);
    check("t1 u2 valid at +3", int'(m_valid2), 1);
    for (int a = 3; a < 32; a++) rd(a, 1);
    drain("t1");
    check("t1 u1 sum 528", int'(fsum1), 528);
    check("t1 u2 sum 528", int'(fsum2), 528);

    // Writes interleaved with reads, different data pattern.
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 3);
    for (int a = 0; a < 32; a++) begin
      rd(a, 1);
      wr((a * 5) % 32);
    end
    drain("t2");

    // Full FIFO with pop and push landing in the same cycle.
    for (int i = 0; i < 32; i++) mem[i] = 8'(i + 1);
    m_ready = 1'b0;
    for (int a = 0; a < 5; a++) rd(a, 1);
    check("t4 u1 level full", int'(lvl1), 4);
    m_ready = 1'b1;
    rd(5, 1);
    check("t4 u1 level stays 4", int'(lvl1), 4);
    check("t4 u1 no overflow", int'(ovf1), 0);
    for (int a = 6; a < 32; a++) rd(a, 1);
    drain("t4");
    check("t4 u1 ovf clear", int'(ovf1), 0);
    check("t4 u2 ovf clear", int'(ovf2), 0);

    // Stalled consumer: words 4 and 5 dropped but still summed.
    m_ready = 1'b0;
    for (int a = 0; a < 4; a++) rd(a, 1);
    rd(4, 0);
    check("t3 u1 ovf not yet", int'(ovf1), 0);
    rd(5, 0);
    check("t3 u1 ovf after 5th", int'(ovf1), 1);
    check("t3 u2 ovf not yet", int'(ovf2), 0);
    idle(2);
    check("t3 u1 level sat", int'(lvl1), 4);
    check("t3 u2 level sat", int'(lvl2), 4);
    check("t3 u2 ovf", int'(ovf2), 1);
    m_ready = 1'b1;
    for (int a = 6; a < 32; a++) rd(a, 1);
    drain("t3");
    check("t3 u1 sum with drops", int'(fsum1), 528);
    check("t3 u1 ovf sticky", int'(ovf1), 1);

    // Reset mid-frame with buffered and in-flight reads.
    m_ready = 1'b0;
    for (int a = 0; a < 4; a++) rd(a, 1);
    check("t6 u1 level 3", int'(lvl1), 3);
    rst = 1'b1; ena = 1'b0; wea = 1'b0;
    step();
    exp1.delete(); exp2.delete(); sq1.delete(); sq2.delete();
    b_acc = '0;
    check_zero("t6 post-reset");
    step();
    check("t6 u1 in-flight gone", int'(m_valid1), 0);
    rst = 1'b0;
    m_ready = 1'b1;
    for (int a = 0; a < 32; a++) rd(a, 1);
    drain("t6");
    check("t6 u1 fresh sum", int'(fsum1), 528);
    check("t6 u2 fresh sum", int'(fsum2), 528);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
